complex_addsub_pipe: RTL
========================

// Module: complex_addsub_pipe
// PURPOSE
//  Pipelined complex fixed-point add / subtract / accumulate unit for the convolution datapath.
//  Takes a pair of complex Q(QI.QF) operands under a valid/ready handshake.
//  Produces a one-guard-bit complex result Q(QI+1.QF) with selectable saturation or wrap.
//  Reports per-beat and sticky overflow. Feeds the accumulate stage of the FFT/convolution MAC path.
// PARAMETERS
//  QI   3  integer bits of inputs (sign included); input width WI = QI+QF
//  QF   3  fractional bits (inputs and outputs)
//  SAT  1  1: saturate on overflow; 0: two's-complement wrap
//  (derived) WO = QI+1+QF output width; full-precision internal width WF = WI+2
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   unit can accept a beat this cycle
//  mode       in   2   00 c=a+b, 01 c=a-b, 10 acc+=a (c=acc), 11 acc=a (c=acc)
//  a_Re,a_Im  in   WI  signed operand A
//  b_Re,b_Im  in   WI  signed operand B (ignored in modes 10/11)
//  out_valid  out  1   result beat valid
//  out_ready  in   1   downstream accepts result
//  c_Re,c_Im  out  WO  signed result
//  overflow   out  1   result beat clipped/wrapped (Re or Im)
//  ovf_sticky out  1   OR of all overflow beats since reset/clear
//  clr_ovf    in   1   synchronous clear of ovf_sticky
// BEHAVIOUR
//  Reset (async, rst_n=0): all valids=0, c_Re=c_Im=0, overflow=0, ovf_sticky=0, acc_Re=acc_Im=0.
//   Takes effect immediately mid-operation; in-flight beats are discarded.
//  Pipeline: two register stages, stall-all. en = ~out_valid | out_ready; in_ready = en (comb).
//   Accept = in_valid & in_ready.
//   Beat accepted at edge k -> out_valid=1 after edge k+1 (latency 2).
//   Full throughput when out_ready=1.
//   out_valid=1 & out_ready=0: stage regs and outputs hold bit-stable; in_ready=0.
//   Output fields change only when out_valid & out_ready, or when out_valid=0.
//  Stage 1 (on accept): sign-extend operands to WF.
//   Modes 00/01: compute sum/diff in WF.
//   Modes 00/01 cannot exceed WO range, so overflow=0 always.
//   Mode 10: s = acc + sext(a) in WF.
//    Overflow if s outside [-2^(WO-1), 2^(WO-1)-1], checked per component.
//    acc <= SAT ? clamp(s) : s[WO-1:0].
//   Mode 11: acc <= sext(a); overflow=0.
//   Modes 10/11: stage-1 result = new acc value.
//   acc updates only on accept, never during stall. Modes 00/01 leave acc unchanged.
//  Stage 2: register result (already in WO) and overflow = ovf_Re | ovf_Im.
//  Clamp values: max = +2^(WO-1)-1 (0x3F for WO=7), min = -2^(WO-1) (0x40).
//  ovf_sticky: set on the cycle an overflow=1 beat is presented with out_valid.
//   Cleared by clr_ovf. Set and clear in the same cycle: set wins.
//  Re and Im paths are independent; no rounding (fractional bits aligned).
//  Mode may change every beat; the mode value is captured with the beat.
// TESTING
//  (QI=3,QF=3, raw integers, LSB=0.125)
//  T1 add: a_Re=28, b_Re=18, a_Im=-5, b_Im=-7, mode 00.
//   -> 2 cycles later c_Re=46, c_Im=-12, overflow=0.
//  T2 sub extreme: a=-32, b=31 (both Re/Im), mode 01.
//   -> c=-63, overflow=0; a=31, b=-32 -> c=63.
//  T3 acc saturate (SAT=1): mode 11 a=31; mode 10 a=31; mode 10 a=31.
//   -> c=31, 62, 63 with overflow 0, 0, 1; ovf_sticky=1 after third beat.
//  T4 acc wrap (SAT=0): same sequence -> c=31, 62, -35, overflow on third beat.
//   Next mode 10 a=0 -> c=-35.
//  T5 backpressure: stream 4 add beats while out_ready=0.
//   -> only 2 accepted, in_ready=0, c holds first result.
//   Release out_ready -> all 4 delivered in order, none lost or duplicated.
//  T6 reset mid-stream: assert rst_n=0 between clock edges with out_valid=1.
//   -> out_valid, c, overflow, ovf_sticky, acc all 0 immediately.
//   After release, mode 10 a=5 -> c=5.
//   Also: clr_ovf with a concurrent overflow beat -> ovf_sticky stays 1.

Source files
------------

// File: rtl/complex_addsub_pipe.sv
// complex_addsub_pipe: two-stage complex add/sub/accumulate with guard bit, saturate or wrap, and overflow flags
module complex_addsub_pipe #(
  parameter int QI = 3,
  parameter int QF = 3,
  parameter bit SAT = 1'b1,
  localparam int WI = QI + QF,
  localparam int WO = WI + 1,
  localparam int WF = WI + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [WI-1:0] a_Re,
  input  logic [WI-1:0] a_Im,
  input  logic [WI-1:0] b_Re,
  input  logic [WI-1:0] b_Im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WO-1:0] c_Re,
  output logic [WO-1:0] c_Im,
  output logic          overflow,
  output logic          ovf_sticky,
  input  logic          clr_ovf
);
  localparam logic signed [WF-1:0] smax = WF'(2 ** (WO - 1) - 1);
  localparam logic signed [WF-1:0] smin = -WF'(2 ** (WO - 1));
  // Returns {overflow, result}; only the accumulate mode can leave the WO range.
  function automatic logic [WO:0] calc(input logic [1:0] m, input logic signed [WO-1:0] acc,
                                       input logic signed [WI-1:0] a, input logic signed [WI-1:0] b);
    logic signed [WF-1:0] ae, be, ce, s;
    logic hi, lo;
    ae = {{(WF-WI){a[WI-1]}}, a};
    be = {{(WF-WI){b[WI-1]}}, b};
    ce = {{(WF-WO){acc[WO-1]}}, acc};
    s = m[1] ? (m[0] ? ae : ce + ae) : (m[0] ? ae - be : ae + be);
    hi = s > smax;
    lo = s < smin;
    return {hi | lo, (SAT && hi) ? smax[WO-1:0] : (SAT && lo) ? smin[WO-1:0] : s[WO-1:0]};
  endfunction
  logic en, accept, v1, o1;
  logic [WO:0] re_n, im_n;
  logic signed [WO-1:0] acc_re, acc_im, r1_re, r1_im;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept = in_valid & en;
  always_comb begin
    re_n = calc(mode, acc_re, a_Re, b_Re);
    im_n = calc(mode, acc_im, a_Im, b_Im);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      o1 <= 1'b0;
      r1_re <= '0;
      r1_im <= '0;
      acc_re <= '0;
      acc_im <= '0;
      out_valid <= 1'b0;
      c_Re <= '0;
      c_Im <= '0;
      overflow <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        r1_re <= re_n[WO-1:0];
        r1_im <= im_n[WO-1:0];
        o1 <= in_valid & (re_n[WO] | im_n[WO]);
        out_valid <= v1;
        c_Re <= r1_re;
        c_Im <= r1_im;
        overflow <= o1;
      end
      if (accept & mode[1]) begin
        acc_re <= re_n[WO-1:0];
        acc_im <= im_n[WO-1:0];
      end
      ovf_sticky <= (out_valid & overflow) | (ovf_sticky & ~clr_ovf);
    end
  end
endmodule
